em_counter_n: RTL and testbench

- Parametrised synchronous counter; next generation of the 4-bit 74161-style up counter in the TTL emulation library.
- Generalised in width and modulus, covering binary (74161/74163) and decade (74160/74162) counts.
- Adds up/down direction (74190/74191 style) and an optional saturate-at-terminal mode.
- Cascadable through ent/rco; used by EDUC-8 program counter, step counter and timing-chain emulation.

---
 rtl/em_ttl_pkg.sv | 20 ++
 rtl/em_cnt_next.sv | 39 +++
 rtl/em_counter_n.sv | 56 +++++
 tb/tb_em_counter_n.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/em_ttl_pkg.sv
// rtl/em_ttl_pkg.sv - shared constants and helpers for the TTL emulation counters
package em_ttl_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits needed to hold values 0..value-1, for instantiators sizing WIDTH.
  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/em_cnt_next.sv
// rtl/em_cnt_next.sv - combinational next count for the modulus up/down counter
module em_cnt_next
  import em_ttl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [31:0]      MOD32   = 32'(MODULUS);
  localparam logic [31:0]      LAST32  = 32'(MODULUS - 1);

  logic [31:0]      count_wide;
  logic [WIDTH-1:0] terminal;

  assign count_wide = 32'(count);
  assign terminal   = (up == DIR_UP) ? MAX_VAL : '0;

  // Out-of-range values (possible only after a load) recover like a real part.
  always_comb begin
    next_count = count;
    if ((SATURATE != 0) && (count == terminal)) begin
      next_count = count;
    end else if (up == DIR_UP) begin
      if (count_wide >= LAST32) next_count = '0;
      else                      next_count = count + ONE;
    end else begin
      if ((count == '0) || (count_wide >= MOD32)) next_count = MAX_VAL;
      else                                       next_count = count - ONE;
    end
  end

endmodule

// File: rtl/em_counter_n.sv
// rtl/em_counter_n.sv - cascadable modulus-N up/down counter with optional saturation
module em_counter_n
  import em_ttl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             ent,
  input  logic             enp,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             rco
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  if ((WIDTH < 1) || (WIDTH > 16)) begin : g_bad_width
    $error("em_counter_n: WIDTH must be 1..16");
  end
  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
    $error("em_counter_n: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] next_count;

  em_cnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .count     (count),
    .up        (up),
    .next_count(next_count)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= parallel_in;
    end else if (ent && enp) begin
      count <= next_count;
    end
  end

  // Flags stay combinational so cascaded stages see carry in the same cycle.
  assign tc  = (up == DIR_UP) ? (count == MAX_VAL) : (count == '0);
  assign rco = tc & ent;

endmodule

// File: tb/tb_em_counter_n.sv
// tb/tb_em_counter_n.sv - randomized self-checking bench for em_counter_n
module tb_em_counter_n;

  logic clk;
  int checks;
  int errors;

  logic a_clr, a_load, a_ent, a_enp, a_up;
  logic [3:0] a_pin, a_count;
  logic a_tc, a_rco;
  logic d_clr, d_load, d_ent, d_enp, d_up;
  logic [3:0] d_pin, d_count;
  logic d_tc, d_rco;
  logic s_clr, s_load, s_ent, s_enp, s_up;
  logic [3:0] s_pin, s_count;
  logic s_tc, s_rco;
  logic k_clr, k_enp, k_up, k_one, k_load;
  logic [3:0] k_pin, k0_count, k1_count;
  logic k0_tc, k0_rco, k1_tc, k1_rco;

  em_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_bin (
    .clk(clk), .clr(a_clr), .load(a_load), .parallel_in(a_pin), .ent(a_ent), .enp(a_enp),
    .up(a_up), .count(a_count), .tc(a_tc), .rco(a_rco));
  em_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dec (
    .clk(clk), .clr(d_clr), .load(d_load), .parallel_in(d_pin), .ent(d_ent), .enp(d_enp),
    .up(d_up), .count(d_count), .tc(d_tc), .rco(d_rco));
  em_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(1)) u_sat (
    .clk(clk), .clr(s_clr), .load(s_load), .parallel_in(s_pin), .ent(s_ent), .enp(s_enp),
    .up(s_up), .count(s_count), .tc(s_tc), .rco(s_rco));
  em_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_k0 (
    .clk(clk), .clr(k_clr), .load(k_load), .parallel_in(k_pin), .ent(k_one), .enp(k_enp),
    .up(k_up), .count(k0_count), .tc(k0_tc), .rco(k0_rco));
  em_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_k1 (
    .clk(clk), .clr(k_clr), .load(k_load), .parallel_in(k_pin), .ent(k0_rco), .enp(k_enp),
    .up(k_up), .count(k1_count), .tc(k1_tc), .rco(k1_rco));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: count states are the integers 0..m-1, stepping is modular arithmetic.
  function automatic int model_next(int c, int m, bit sat, logic clr, logic load,
                                    logic ent, logic enp, logic up, logic [3:0] pin);
    if (clr) return 0;
    if (load) return int'(pin);
    if (!(ent && enp)) return c;
    if (sat && (c == (up ? m - 1 : 0))) return c;
    if (c >= m) return up ? 0 : m - 1;
    return up ? (c + 1) % m : (c + m - 1) % m;
  endfunction

  function automatic bit model_tc(int c, int m, logic up);
    return up ? (c == m - 1) : (c == 0);
  endfunction

  task automatic rand_in(output logic clr, output logic load, output logic ent,
                         output logic enp, output logic up, output logic [3:0] pin);
    clr  = ($urandom_range(0, 15) == 0);
    load = ($urandom_range(0, 7) == 0);
    ent  = ($urandom_range(0, 3) != 0);
    enp  = ($urandom_range(0, 3) != 0);
    up   = 1'($urandom_range(0, 1));
    pin  = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset;
    a_clr = 1; a_load = 0; a_ent = 1; a_enp = 1; a_up = 0; a_pin = 4'd5;
    tick();
    checks++;
    if (a_count !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", a_count);
    end
    checks++;
    if (a_tc !== 1'b1 || a_rco !== 1'b1) begin
      errors++; $display("FAIL reset_down_flags: got tc=%b rco=%b want tc=1 rco=1", a_tc, a_rco);
    end
    a_up = 1;
    #1;
    checks++;
    if (a_tc !== 1'b0 || a_rco !== 1'b0) begin
      errors++; $display("FAIL reset_up_flags: got tc=%b rco=%b want tc=0 rco=0", a_tc, a_rco);
    end
    a_clr = 0;
  endtask

  task automatic test_binary_up;
    int exp;
    a_clr = 1; a_load = 0; a_up = 1; a_ent = 1; a_enp = 1;
    tick();
    a_clr = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp = i % 16;
      checks++;
      if (a_count !== 4'(exp) || a_tc !== (exp == 15) || a_rco !== (exp == 15)) begin
        errors++;
        $display("FAIL binary_up step %0d: got count=%0d tc=%b rco=%b want count=%0d tc=rco=%b",
                 i, a_count, a_tc, a_rco, exp, exp == 15);
      end
    end
  endtask

  task automatic test_decade_down;
    int seq[5] = '{2, 1, 0, 9, 8};
    d_clr = 0; d_load = 1; d_pin = 4'd3; d_up = 0; d_ent = 1; d_enp = 1;
    tick();
    d_load = 0;
    checks++;
    if (d_count !== 4'd3) begin
      errors++; $display("FAIL decade_load3: got %0d want 3", d_count);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (d_count !== 4'(seq[i]) || d_rco !== (seq[i] == 0)) begin
        errors++;
        $display("FAIL decade_down step %0d: got count=%0d rco=%b want count=%0d rco=%b",
                 i, d_count, d_rco, seq[i], seq[i] == 0);
      end
    end
    d_load = 1; d_pin = 4'd0;
    tick();
    d_load = 0; d_ent = 0;
    #1;
    checks++;
    if (d_tc !== 1'b1 || d_rco !== 1'b0) begin
      errors++; $display("FAIL decade_tc_no_ent: got tc=%b rco=%b want tc=1 rco=0", d_tc, d_rco);
    end
    tick();
    checks++;
    if (d_count !== 4'd0) begin
      errors++; $display("FAIL decade_hold_no_ent: got %0d want 0", d_count);
    end
  endtask

  task automatic test_illegal_load;
    d_clr = 0; d_load = 1; d_pin = 4'd12; d_up = 1; d_ent = 1; d_enp = 1;
    tick();
    checks++;
    if (d_count !== 4'd12) begin
      errors++; $display("FAIL illegal_stored: got %0d want 12", d_count);
    end
    d_load = 0;
    tick();
    checks++;
    if (d_count !== 4'd0) begin
      errors++; $display("FAIL illegal_up_recover: got %0d want 0", d_count);
    end
    d_load = 1;
    tick();
    d_load = 0; d_up = 0;
    tick();
    checks++;
    if (d_count !== 4'd9) begin
      errors++; $display("FAIL illegal_down_recover: got %0d want 9", d_count);
    end
  endtask

  task automatic test_saturate;
    s_clr = 0; s_load = 1; s_pin = 4'd14; s_up = 1; s_ent = 1; s_enp = 1;
    tick();
    s_load = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (s_count !== 4'd15 || s_rco !== 1'b1) begin
        errors++;
        $display("FAIL saturate_hold step %0d: got count=%0d rco=%b want count=15 rco=1",
                 i, s_count, s_rco);
      end
    end
    s_up = 0;
    #1;
    checks++;
    if (s_tc !== 1'b0) begin
      errors++; $display("FAIL saturate_dir_tc: got %b want 0", s_tc);
    end
    tick();
    checks++;
    if (s_count !== 4'd14) begin
      errors++; $display("FAIL saturate_down: got %0d want 14", s_count);
    end
  endtask

  task automatic test_cascade;
    int exp;
    k_clr = 1; k_load = 0; k_pin = 4'd0; k_enp = 1; k_up = 1; k_one = 1;
    tick();
    k_clr = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      exp = i % 100;
      checks++;
      if (k1_count !== 4'(exp / 10) || k0_count !== 4'(exp % 10) ||
          k1_rco !== (exp == 99) || k0_tc !== (exp % 10 == 9) || k1_tc !== (exp / 10 == 9)) begin
        errors++;
        $display("FAIL cascade step %0d: got %0d%0d rco1=%b want %0d rco1=%b",
                 i, k1_count, k0_count, k1_rco, exp, exp == 99);
      end
    end
  endtask

  task automatic test_priority;
    a_clr = 0; a_load = 1; a_pin = 4'd3; a_up = 1; a_ent = 1; a_enp = 1;
    tick();
    a_clr = 1; a_pin = 4'd7;
    tick();
    checks++;
    if (a_count !== 4'd0) begin
      errors++; $display("FAIL prio_clr: got %0d want 0", a_count);
    end
    a_clr = 0; a_ent = 0; a_enp = 0;
    tick();
    checks++;
    if (a_count !== 4'd7) begin
      errors++; $display("FAIL prio_load: got %0d want 7", a_count);
    end
    a_load = 0; a_ent = 1;
    tick();
    checks++;
    if (a_count !== 4'd7) begin
      errors++; $display("FAIL prio_hold: got %0d want 7", a_count);
    end
  endtask

  task automatic test_random;
    int ma, md, ms;
    a_clr = 1; d_clr = 1; s_clr = 1; a_load = 0; d_load = 0; s_load = 0;
    tick();
    ma = 0; md = 0; ms = 0;
    for (int i = 0; i < 400; i++) begin
      rand_in(a_clr, a_load, a_ent, a_enp, a_up, a_pin);
      rand_in(d_clr, d_load, d_ent, d_enp, d_up, d_pin);
      rand_in(s_clr, s_load, s_ent, s_enp, s_up, s_pin);
      ma = model_next(ma, 16, 0, a_clr, a_load, a_ent, a_enp, a_up, a_pin);
      md = model_next(md, 10, 0, d_clr, d_load, d_ent, d_enp, d_up, d_pin);
      ms = model_next(ms, 16, 1, s_clr, s_load, s_ent, s_enp, s_up, s_pin);
      tick();
      checks++;
      if (a_count !== 4'(ma) || a_tc !== model_tc(ma, 16, a_up) ||
          a_rco !== (model_tc(ma, 16, a_up) && a_ent)) begin
        errors++;
        $display("FAIL random_bin %0d: got count=%0d tc=%b rco=%b want count=%0d",
                 i, a_count, a_tc, a_rco, ma);
      end
      checks++;
      if (d_count !== 4'(md) || d_tc !== model_tc(md, 10, d_up) ||
          d_rco !== (model_tc(md, 10, d_up) && d_ent)) begin
        errors++;
        $display("FAIL random_dec %0d: got count=%0d tc=%b rco=%b want count=%0d",
                 i, d_count, d_tc, d_rco, md);
      end
      checks++;
      if (s_count !== 4'(ms) || s_tc !== model_tc(ms, 16, s_up) ||
          s_rco !== (model_tc(ms, 16, s_up) && s_ent)) begin
        errors++;
        $display("FAIL random_sat %0d: got count=%0d tc=%b rco=%b want count=%0d",
                 i, s_count, s_tc, s_rco, ms);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    a_clr = 1; a_load = 0; a_ent = 0; a_enp = 0; a_up = 1; a_pin = '0;
    d_clr = 1; d_load = 0; d_ent = 0; d_enp = 0; d_up = 1; d_pin = '0;
    s_clr = 1; s_load = 0; s_ent = 0; s_enp = 0; s_up = 1; s_pin = '0;
    k_clr = 1; k_load = 0; k_enp = 0; k_up = 1; k_one = 1; k_pin = '0;
    test_reset();
    test_binary_up();
    test_decade_down();
    test_illegal_load();
    test_saturate();
    test_cascade();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
